// File: rtl/wb_trace_serializer_if.sv
// ---------------------------------------------------------------------------
// wb_trace_serializer_if
// Bundle between the dual-issue writeback stage and the trace serializer.
//   W_master_* / W_slave_* : retiring instruction slots (valid pulse, pc,
//                            regfile write enable, destination, write data)
//   debug_wb_*             : single-retire debug trace port
//   trace_stall_req        : hold retirement while the FIFO is nearly full
//   trace_overflow         : sticky, at least one retiring entry was dropped
// Modports:
//   master : pipeline side (drives the retire slots, observes the trace)
//   slave  : serializer side
// ---------------------------------------------------------------------------
interface wb_trace_serializer_if;
  logic        W_master_valid;
  logic [31:0] W_master_pc;
  logic        W_master_reg_wen;
  logic [4:0]  W_master_reg_waddr;
  logic [31:0] W_master_reg_wdata;
  logic        W_slave_valid;
  logic [31:0] W_slave_pc;
  logic        W_slave_reg_wen;
  logic [4:0]  W_slave_reg_waddr;
  logic [31:0] W_slave_reg_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        trace_stall_req;
  logic        trace_overflow;

  modport master (
    output W_master_valid, W_master_pc, W_master_reg_wen, W_master_reg_waddr, W_master_reg_wdata,
    output W_slave_valid, W_slave_pc, W_slave_reg_wen, W_slave_reg_waddr, W_slave_reg_wdata,
    input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
    input  trace_stall_req, trace_overflow
  );

  modport slave (
    input  W_master_valid, W_master_pc, W_master_reg_wen, W_master_reg_waddr, W_master_reg_wdata,
    input  W_slave_valid, W_slave_pc, W_slave_reg_wen, W_slave_reg_waddr, W_slave_reg_wdata,
    output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
    output trace_stall_req, trace_overflow
  );
endinterface

// File: rtl/wb_trace_serializer.sv
// ---------------------------------------------------------------------------
// wb_trace_serializer
// Serializes up to two retiring instructions per cycle (master first, then
// slave) through a DEPTH-entry FIFO onto a single-retire debug trace port.
// Ports:
//   clk : clock, all state on posedge
//   rst : asynchronous active-low reset
//   bus : wb_trace_serializer_if.slave (retire slots in, trace port out)
// ---------------------------------------------------------------------------
module wb_trace_serializer #(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input logic                  clk,
  input logic                  rst,
  wb_trace_serializer_if.slave bus
);
  localparam int PTR_W = CNT_W - 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, wr_ptr_plus1;
  logic [CNT_W-1:0] count_reg, count_next, free, push_cnt;
  entry_t           m_entry, s_entry, first_entry, head;
  logic             push_first, push_second, drop, pop;

  // Writes to r0 are architecturally invisible, so they are traced as no-write.
  assign m_entry = '{pc: bus.W_master_pc,
                     wen: bus.W_master_reg_wen && (bus.W_master_reg_waddr != 5'd0),
                     waddr: bus.W_master_reg_waddr, wdata: bus.W_master_reg_wdata};
  assign s_entry = '{pc: bus.W_slave_pc,
                     wen: bus.W_slave_reg_wen && (bus.W_slave_reg_waddr != 5'd0),
                     waddr: bus.W_slave_reg_waddr, wdata: bus.W_slave_reg_wdata};

  // Space is judged on the pre-edge count; a same-edge pop frees nothing yet.
  assign free         = CNT_W'(DEPTH) - count_reg;
  assign pop          = (count_reg != '0);
  assign wr_ptr_plus1 = wr_ptr_reg + PTR_W'(1);

  always_comb begin
    push_first  = 1'b0;
    push_second = 1'b0;
    drop        = 1'b0;
    first_entry = m_entry;
    if (bus.W_master_valid && bus.W_slave_valid) begin
      if (free >= CNT_W'(2)) begin
        push_first  = 1'b1;
        push_second = 1'b1;
      end else if (free == CNT_W'(1)) begin
        push_first = 1'b1;
        drop       = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (bus.W_master_valid || bus.W_slave_valid) begin
      first_entry = bus.W_master_valid ? m_entry : s_entry;
      if (free != '0) push_first = 1'b1;
      else            drop       = 1'b1;
    end
  end

  assign push_cnt   = CNT_W'(push_first) + CNT_W'(push_second);
  assign count_next = count_reg + push_cnt - CNT_W'(pop);

  // Storage carries no reset so it maps onto plain RAM; the read is
  // registered into the trace outputs below. A push never targets the head
  // slot being read on the same edge because it only lands in free slots.
  always_ff @(posedge clk) begin
    if (push_first)  mem[wr_ptr_reg]   <= first_entry;
    if (push_second) mem[wr_ptr_plus1] <= s_entry;
  end

  assign head = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg            <= '0;
      rd_ptr_reg            <= '0;
      count_reg             <= '0;
      bus.debug_wb_pc       <= '0;
      bus.debug_wb_rf_wen   <= '0;
      bus.debug_wb_rf_wnum  <= '0;
      bus.debug_wb_rf_wdata <= '0;
      bus.trace_overflow    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(push_cnt);
      count_reg  <= count_next;
      if (drop) bus.trace_overflow <= 1'b1;
      if (pop) begin
        rd_ptr_reg            <= rd_ptr_reg + PTR_W'(1);
        bus.debug_wb_pc       <= head.pc;
        bus.debug_wb_rf_wen   <= {4{head.wen}};
        bus.debug_wb_rf_wnum  <= head.waddr;
        bus.debug_wb_rf_wdata <= head.wdata;
      end else begin
        bus.debug_wb_pc       <= '0;
        bus.debug_wb_rf_wen   <= '0;
        bus.debug_wb_rf_wnum  <= '0;
        bus.debug_wb_rf_wdata <= '0;
      end
    end
  end

  // Two slots of headroom absorb the pair already in flight on the edge
  // where this first rises.
  assign bus.trace_stall_req = (count_reg >= CNT_W'(DEPTH - 2));
endmodule

// File: tb/tb_wb_trace_serializer.sv
// ---------------------------------------------------------------------------
// tb_wb_trace_serializer
// Directed bench for wb_trace_serializer (DEPTH=8): a vector table for the
// basic single/dual/r0 cases plus hand-written fill, wrap and reset sequences.
// ---------------------------------------------------------------------------
module tb_wb_trace_serializer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] got[$];
  logic [31:0] exp_q[$];

  wb_trace_serializer_if bus ();

  wb_trace_serializer #(.DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mv;
    logic [31:0] mpc;
    logic        mwen;
    logic [4:0]  mwa;
    logic [31:0] mwd;
    logic        sv;
    logic [31:0] spc;
    logic        swen;
    logic [4:0]  swa;
    logic [31:0] swd;
    logic [31:0] epc;
    logic [3:0]  ewen;
    logic [4:0]  ewnum;
    logic [31:0] ewd;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic v, input logic [31:0] pc, input logic wen,
                       input logic [4:0] wa, input logic [31:0] wd);
    bus.W_master_valid     = v;
    bus.W_master_pc        = pc;
    bus.W_master_reg_wen   = wen;
    bus.W_master_reg_waddr = wa;
    bus.W_master_reg_wdata = wd;
  endtask

  task automatic set_s(input logic v, input logic [31:0] pc, input logic wen,
                       input logic [4:0] wa, input logic [31:0] wd);
    bus.W_slave_valid     = v;
    bus.W_slave_pc        = pc;
    bus.W_slave_reg_wen   = wen;
    bus.W_slave_reg_waddr = wa;
    bus.W_slave_reg_wdata = wd;
  endtask

  task automatic idle();
    set_m(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_s(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Instruction i of a sequence: nonzero pc, nonzero destination, wen=1.
  task automatic put_m(input logic [31:0] base, input int i);
    set_m(1'b1, base + 32'(4 * i), 1'b1, 5'((i % 31) + 1), 32'hA5A50000 ^ 32'(i));
  endtask

  task automatic put_s(input logic [31:0] base, input int i);
    set_s(1'b1, base + 32'(4 * i), 1'b1, 5'((i % 31) + 1), 32'hA5A50000 ^ 32'(i));
  endtask

  task automatic cap();
    if (bus.debug_wb_pc != 32'h0) begin
      got.push_back(bus.debug_wb_pc);
      $display("trace pc=%h wen=%h wnum=%0d", bus.debug_wb_pc, bus.debug_wb_rf_wen, bus.debug_wb_rf_wnum);
      chk("cap_wen", 32'(bus.debug_wb_rf_wen), 32'hF);
    end
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic cmp_queues(input string nm);
    chk({nm, "_n"}, 32'(got.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got.size(); k++)
      chk({nm, "_pc"}, got[k], exp_q[k]);
  endtask

  initial begin
    int nxt, cyc, stale;
    bit dual_turn;

    //            mv   mpc           mwen mwa    mwd         sv   spc          swen swa    swd          epc           ewen   ewnum  ewd
    vecs[0]  = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,     1'b0, 32'h0,     1'b0, 5'd0,  32'h0,      32'h0,        4'h0, 5'd0,  32'h0};
    vecs[1]  = '{1'b1, 32'hBFC00000, 1'b1, 5'd5, 32'h1234,  1'b0, 32'h0,     1'b0, 5'd0,  32'h0,      32'h0,        4'h0, 5'd0,  32'h0};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,     1'b0, 32'h0,     1'b0, 5'd0,  32'h0,      32'hBFC00000, 4'hF, 5'd5,  32'h1234};
    vecs[3]  = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,     1'b0, 32'h0,     1'b0, 5'd0,  32'h0,      32'h0,        4'h0, 5'd0,  32'h0};
    vecs[4]  = '{1'b1, 32'h100,      1'b1, 5'd0, 32'hAA,    1'b1, 32'h104,   1'b1, 5'd3,  32'hBB,     32'h0,        4'h0, 5'd0,  32'h0};
    vecs[5]  = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,     1'b0, 32'h0,     1'b0, 5'd0,  32'h0,      32'h100,      4'h0, 5'd0,  32'hAA};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,     1'b0, 32'h0,     1'b0, 5'd0,  32'h0,      32'h104,      4'hF, 5'd3,  32'hBB};
    vecs[7]  = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,     1'b1, 32'h200,   1'b0, 5'd7,  32'hCC,     32'h0,        4'h0, 5'd0,  32'h0};
    vecs[8]  = '{1'b1, 32'h300,      1'b1, 5'd9, 32'hDD,    1'b0, 32'h0,     1'b0, 5'd0,  32'h0,      32'h200,      4'h0, 5'd7,  32'hCC};
    vecs[9]  = '{1'b1, 32'h304,      1'b1, 5'd10, 32'hEE,   1'b1, 32'h308,   1'b0, 5'd11, 32'hFF,     32'h300,      4'hF, 5'd9,  32'hDD};
    vecs[10] = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,     1'b0, 32'h0,     1'b0, 5'd0,  32'h0,      32'h304,      4'hF, 5'd10, 32'hEE};
    vecs[11] = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,     1'b0, 32'h0,     1'b0, 5'd0,  32'h0,      32'h308,      4'h0, 5'd11, 32'hFF};
    vecs[12] = '{1'b0, 32'h0,        1'b0, 5'd0, 32'h0,     1'b0, 32'h0,     1'b0, 5'd0,  32'h0,      32'h0,        4'h0, 5'd0,  32'h0};

    // Reset, checked while held and right after release.
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", bus.debug_wb_pc, 32'h0);
    chk("rst_ovf", 32'(bus.trace_overflow), 32'h0);
    rst = 1'b1;
    step();
    chk("idle_wen", 32'(bus.debug_wb_rf_wen), 32'h0);
    chk("idle_stall", 32'(bus.trace_stall_req), 32'h0);

    // Vector table: inputs sit across one edge, outputs checked after it.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      set_m(vecs[i].mv, vecs[i].mpc, vecs[i].mwen, vecs[i].mwa, vecs[i].mwd);
      set_s(vecs[i].sv, vecs[i].spc, vecs[i].swen, vecs[i].swa, vecs[i].swd);
      step();
      $display("vec %0d pc=%h wen=%h wnum=%0d wdata=%h", i, bus.debug_wb_pc,
               bus.debug_wb_rf_wen, bus.debug_wb_rf_wnum, bus.debug_wb_rf_wdata);
      chk("vec_pc", bus.debug_wb_pc, vecs[i].epc);
      chk("vec_wen", 32'(bus.debug_wb_rf_wen), 32'(vecs[i].ewen));
      chk("vec_wnum", 32'(bus.debug_wb_rf_wnum), 32'(vecs[i].ewnum));
      chk("vec_wdata", bus.debug_wb_rf_wdata, vecs[i].ewd);
      chk("vec_stall", 32'(bus.trace_stall_req), 32'h0);
      chk("vec_ovf", 32'(bus.trace_overflow), 32'h0);
    end

    // Fill ignoring stall: pairs 0..11 fit, then count sits at 7 and only
    // the master of each pair (12,14,16,18) is accepted.
    do_reset();
    got.delete();
    for (int e = 1; e <= 10; e++) begin
      put_m(32'h1000, 2 * (e - 1));
      put_s(32'h1000, 2 * (e - 1) + 1);
      step();
      cap();
      if (e == 4) chk("fill_stall_c5", 32'(bus.trace_stall_req), 32'h0);
      if (e == 5) chk("fill_stall_c6", 32'(bus.trace_stall_req), 32'h1);
      if (e == 6) chk("fill_ovf_pre", 32'(bus.trace_overflow), 32'h0);
      if (e == 7) chk("fill_ovf_post", 32'(bus.trace_overflow), 32'h1);
    end
    idle();
    repeat (10) begin
      step();
      cap();
    end
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back(32'h1000 + 32'(4 * i));
    for (int i = 12; i <= 18; i += 2) exp_q.push_back(32'h1000 + 32'(4 * i));
    cmp_queues("fill");
    chk("fill_ovf_sticky", 32'(bus.trace_overflow), 32'h1);
    chk("fill_stall_end", 32'(bus.trace_stall_req), 32'h0);
    chk("fill_count_end", 32'(dut.count_reg), 32'h0);

    // Wrap-around: dual / slave-only single alternation, honoring stall.
    do_reset();
    got.delete();
    nxt = 0;
    cyc = 0;
    dual_turn = 1'b1;
    while (nxt < 30 && cyc < 200) begin
      if (bus.trace_stall_req) begin
        idle();
      end else if (dual_turn && nxt <= 28) begin
        put_m(32'h2000, nxt);
        put_s(32'h2000, nxt + 1);
        nxt += 2;
        dual_turn = 1'b0;
      end else begin
        set_m(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        put_s(32'h2000, nxt);
        nxt += 1;
        dual_turn = 1'b1;
      end
      step();
      cap();
      cyc++;
    end
    chk("wrap_issue_done", 32'(nxt), 32'd30);
    idle();
    repeat (12) begin
      step();
      cap();
    end
    exp_q.delete();
    for (int i = 0; i < 30; i++) exp_q.push_back(32'h2000 + 32'(4 * i));
    cmp_queues("wrap");
    chk("wrap_ovf", 32'(bus.trace_overflow), 32'h0);
    chk("wrap_count_end", 32'(dut.count_reg), 32'h0);

    // Reset mid-operation with 5 entries queued; the output shows pair
    // member 2 after the fourth edge.
    do_reset();
    for (int e = 1; e <= 4; e++) begin
      put_m(32'h3000, 2 * (e - 1));
      put_s(32'h3000, 2 * (e - 1) + 1);
      step();
    end
    idle();
    chk("mid_pre_pc", bus.debug_wb_pc, 32'h3008);
    chk("mid_pre_count", 32'(dut.count_reg), 32'd5);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_async_pc", bus.debug_wb_pc, 32'h0);
    chk("mid_async_wen", 32'(bus.debug_wb_rf_wen), 32'h0);
    chk("mid_async_wnum", 32'(bus.debug_wb_rf_wnum), 32'h0);
    chk("mid_async_wdata", bus.debug_wb_rf_wdata, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    stale = 0;
    repeat (10) begin
      step();
      if (bus.debug_wb_pc != 32'h0 || bus.debug_wb_rf_wen != 4'h0) stale++;
    end
    chk("mid_stale", 32'(stale), 32'h0);
    chk("mid_count", 32'(dut.count_reg), 32'h0);
    chk("mid_ovf", 32'(bus.trace_overflow), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
